// File: rtl/viterbi_traceback.sv
// Survivor-path store and block traceback for the Viterbi decoder; emits decoded bits oldest-first.
// Optional: define VITERBI_TB_BEST_STATE_EN to start traceback from best_state instead of state 0.
module viterbi_traceback #(
   parameter int unsigned K          = 3,
   parameter int unsigned TB_DEPTH   = 16,
   localparam int unsigned M          = K - 1,
   localparam int unsigned NUM_STATES = 1 << M
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [NUM_STATES-1:0] dec_vec,
   input  logic [M-1:0]          best_state,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_bit,
   output logic                  out_last,
   output logic                  busy
);

   localparam int unsigned PW = $clog2(TB_DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_TRACE, ST_OUTPUT} state_e;

   state_e                state_q, state_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         out_ptr_q, out_ptr_d;
   logic [M-1:0]          tb_state_q, tb_state_d;
   logic [NUM_STATES-1:0] mem_q [TB_DEPTH];
   logic [NUM_STATES-1:0] mem_d [TB_DEPTH];
   logic [TB_DEPTH-1:0]   rev_q, rev_d;
   logic [M-1:0]          start_state;

`ifdef VITERBI_TB_BEST_STATE_EN
   assign start_state = best_state;
`else
   // Zero-terminated trellis: traceback always begins at state 0.
   logic unused_best;
   assign unused_best = ^best_state;
   assign start_state = '0;
`endif

   // State and storage registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_ptr_q  <= '0;
         tb_state_q <= '0;
         mem_q      <= '{default: '0};
         rev_q      <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         out_ptr_q  <= out_ptr_d;
         tb_state_q <= tb_state_d;
         mem_q      <= mem_d;
         rev_q      <= rev_d;
      end
   end

   // Next-state and handshake logic; en low freezes everything and masks the handshakes.
   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      out_ptr_d  = out_ptr_q;
      tb_state_d = tb_state_q;
      mem_d      = mem_q;
      rev_d      = rev_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      out_bit    = 1'b0;
      out_last   = 1'b0;
      busy       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (en) state_d = ST_FILL;
         end

         ST_FILL: begin
            in_ready = en;
            if (en && in_valid) begin
               mem_d[wr_ptr_q] = dec_vec;
               if (wr_ptr_q == PW'(TB_DEPTH - 1)) begin
                  wr_ptr_d   = '0;
                  rd_ptr_d   = PW'(TB_DEPTH - 1);
                  tb_state_d = start_state;
                  state_d    = ST_TRACE;
               end else begin
                  wr_ptr_d = wr_ptr_q + PW'(1);
               end
            end
         end

         ST_TRACE: begin
            busy = 1'b1;
            if (en) begin
               rev_d[rd_ptr_q] = tb_state_q[M-1];
               tb_state_d      = {tb_state_q[M-2:0], mem_q[rd_ptr_q][tb_state_q]};
               if (rd_ptr_q == '0) begin
                  out_ptr_d = '0;
                  state_d   = ST_OUTPUT;
               end else begin
                  rd_ptr_d = rd_ptr_q - PW'(1);
               end
            end
         end

         ST_OUTPUT: begin
            busy      = 1'b1;
            out_valid = en;
            out_bit   = rev_q[out_ptr_q];
            out_last  = (out_ptr_q == PW'(TB_DEPTH - 1));
            if (en && out_ready) begin
               if (out_last) begin
                  out_ptr_d = '0;
                  state_d   = ST_FILL;
               end else begin
                  out_ptr_d = out_ptr_q + PW'(1);
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Self-checking bench for viterbi_traceback (K=3, TB_DEPTH=4) against a trellis traceback model.
module tb_viterbi_traceback;

   localparam int unsigned K  = 3;
   localparam int unsigned M  = K - 1;
   localparam int unsigned NS = 1 << M;
   localparam int unsigned D  = 4;

   logic          clk;
   logic          rst;
   logic          en;
   logic          in_valid;
   logic          in_ready;
   logic [NS-1:0] dec_vec;
   logic [M-1:0]  best_state;
   logic          out_valid;
   logic          out_ready;
   logic          out_bit;
   logic          out_last;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int t_first  = 0;
   int t_last   = 0;

   logic [NS-1:0] blk_vec [D];
   logic [M-1:0]  blk_best;
   logic [D-1:0]  exp_bits;
   logic [D-1:0]  exp_lasts;

   viterbi_traceback #(.K(K), .TB_DEPTH(D)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
      .dec_vec(dec_vec), .best_state(best_state), .out_valid(out_valid),
      .out_ready(out_ready), .out_bit(out_bit), .out_last(out_last), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end

   // Reference: walk the survivor path backwards from the start state, one decided bit per step.
   function automatic void model();
      int s;
`ifdef VITERBI_TB_BEST_STATE_EN
      s = int'(blk_best);
`else
      s = 0;
`endif
      for (int t = D - 1; t >= 0; t--) begin
         exp_bits[t] = 1'((s >> (M - 1)) & 1);
         s = ((s * 2) % NS) + int'(blk_vec[t][s]);
      end
      exp_lasts = '0;
      exp_lasts[D-1] = 1'b1;
   endfunction

   task automatic rand_block();
      for (int i = 0; i < D; i++) blk_vec[i] = NS'($urandom);
      blk_best = M'($urandom);
   endtask

   // Drops en for two cycles; flags any handshake seen while en is low.
   task automatic pause_en(output bit err);
      err = 0;
      en  = 1'b0;
      repeat (2) begin
         #1;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) err = 1;
         @(posedge clk); #1;
      end
      en = 1'b1;
   endtask

   task automatic send_block(input int pause_at, input bit hold_valid, output bit to, output bit perr);
      int n;
      to = 0; perr = 0;
      for (int i = 0; i < D; i++) begin
         if (i == pause_at) pause_en(perr);
         in_valid   = 1'b1;
         dec_vec    = blk_vec[i];
         best_state = blk_best;
         n = 0;
         #1;
         while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
         end
         if (n >= 100) to = 1;
         @(posedge clk); #1;
         if (i == 0) t_first = cyc;
      end
      if (!hold_valid) in_valid = 1'b0;
   endtask

   task automatic recv_block(input int stall_idx, input int stall_n, input bit rnd_ready, input int pause_at,
                             output logic [D-1:0] bits, output logic [D-1:0] lasts, output int lat,
                             output bit hold_err, output bit inrdy_err, output bit perr, output bit to);
      int   got = 0;
      int   n = 0;
      int   stall = 0;
      bit   paused = 0;
      logic hb = 1'b0;
      logic hl = 1'b0;
      bits = '0; lasts = '0; lat = 0; hold_err = 0; inrdy_err = 0; perr = 0; to = 0;
      while (got < D && n < 1000) begin
         if (got == pause_at && !paused) begin
            pause_en(perr);
            paused = 1;
         end
         if (got == stall_idx && stall < stall_n) out_ready = 1'b0;
         else out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         if (out_valid === 1'b1) begin
            if (lat == 0) lat = n + 1;
            if (in_ready !== 1'b0) inrdy_err = 1;
            if (got == stall_idx && stall > 0 && (out_bit !== hb || out_last !== hl)) hold_err = 1;
            hb = out_bit; hl = out_last;
            if (out_ready) begin
               bits[got]  = out_bit;
               lasts[got] = out_last;
               got++;
            end else if (got == stall_idx) begin
               stall++;
            end
         end
         @(posedge clk); #1;
         n++;
      end
      t_last    = cyc;
      out_ready = 1'b0;
      to = (got < D);
   endtask

   task automatic check_block(input string name, input logic [D-1:0] bits, input logic [D-1:0] lasts, input bit to);
      // Per-block result checks are done inline by callers; this only prints diagnostic context.
      $display("block %s: bits=%b lasts=%b timeout=%0d", name, bits, lasts, to);
   endtask

   task automatic test_reset();
      bit to, perr, h, ir, pe;
      logic [D-1:0] bits, lasts;
      int lat;
      rst = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dec_vec = '0; best_state = '0;
      #3;
      n_checks++;
      if ({in_ready, out_valid, busy, out_bit, out_last} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 00000", {in_ready, out_valid, busy, out_bit, out_last});
      end
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++; $display("FAIL reset_first_cycle_in_ready: got %b want 0", in_ready);
      end
      @(posedge clk); #2;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_second_cycle_in_ready: got %b want 1", in_ready);
      end
      // Reset during TRACE.
      rand_block();
      send_block(-1, 0, to, perr);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b0) begin
         n_fail++; $display("FAIL reset_mid_trace: got %b want 000", {in_ready, out_valid, busy});
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b1;
      // Reset during FILL after two transfers, then a full block must decode cleanly.
      @(posedge clk); @(posedge clk); #1;
      in_valid = 1'b1; dec_vec = NS'($urandom);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      rand_block();
      model();
      send_block(-1, 0, to, perr);
      recv_block(-1, 0, 0, -1, bits, lasts, lat, h, ir, pe, to);
      n_checks++;
      if (to || bits !== exp_bits || lasts !== exp_lasts) begin
         n_fail++;
         $display("FAIL reset_fill_discard: got bits %b lasts %b to %0d want bits %b lasts %b", bits, lasts, to, exp_bits, exp_lasts);
      end
   endtask

   task automatic test_directed();
      bit to, perr, h, ir, pe;
      logic [D-1:0] bits, lasts, want2, want3;
      int lat;
`ifdef VITERBI_TB_BEST_STATE_EN
      want2 = 4'b1101;
      want3 = 4'b1100;
`else
      want2 = 4'b0000;
      want3 = 4'b0000;
`endif
      blk_vec[0] = 4'b0000; blk_vec[1] = 4'b0000; blk_vec[2] = 4'b0100; blk_vec[3] = 4'b0000;
      blk_best = 2'd3;
      send_block(-1, 0, to, perr);
      recv_block(-1, 0, 0, -1, bits, lasts, lat, h, ir, pe, to);
      n_checks++;
      if (to || bits !== want2) begin
         n_fail++; $display("FAIL directed_bits: got %b (to %0d) want %b", bits, to, want2);
      end
      n_checks++;
      if (lasts !== 4'b1000) begin
         n_fail++; $display("FAIL directed_last: got %b want 1000", lasts);
      end
      n_checks++;
      if (lat != D + 1) begin
         n_fail++; $display("FAIL directed_latency: got %0d want %0d", lat, D + 1);
      end
      n_checks++;
      if (t_last - t_first != 3 * D - 1) begin
         n_fail++; $display("FAIL directed_duration: got %0d want %0d", t_last - t_first, 3 * D - 1);
      end
      for (int i = 0; i < D; i++) blk_vec[i] = '0;
      send_block(-1, 0, to, perr);
      recv_block(-1, 0, 0, -1, bits, lasts, lat, h, ir, pe, to);
      n_checks++;
      if (to || bits !== want3) begin
         n_fail++; $display("FAIL zero_vec_bits: got %b (to %0d) want %b", bits, to, want3);
      end
   endtask

   task automatic test_random();
      bit to_s, to, perr, h, ir, pe;
      logic [D-1:0] bits, lasts;
      int lat;
      for (int b = 0; b < 8; b++) begin
         rand_block();
         model();
         send_block(-1, 0, to_s, perr);
         recv_block(-1, 0, 1, -1, bits, lasts, lat, h, ir, pe, to);
         n_checks++;
         if (to_s || to || bits !== exp_bits || lasts !== exp_lasts) begin
            n_fail++;
            $display("FAIL random_block%0d: got bits %b lasts %b want bits %b lasts %b", b, bits, lasts, exp_bits, exp_lasts);
         end
      end
   endtask

   task automatic test_backpressure();
      bit to, perr, h, ir, pe;
      logic [D-1:0] bits, lasts;
      int lat;
      rand_block();
      model();
      send_block(-1, 0, to, perr);
      recv_block(2, 3, 0, -1, bits, lasts, lat, h, ir, pe, to);
      n_checks++;
      if (to || bits !== exp_bits || lasts !== exp_lasts) begin
         n_fail++; $display("FAIL backpressure_data: got bits %b lasts %b want bits %b lasts %b", bits, lasts, exp_bits, exp_lasts);
      end
      n_checks++;
      if (h !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_hold: got changed=%0d want 0", h);
      end
      n_checks++;
      if (ir !== 1'b0) begin
         n_fail++; $display("FAIL backpressure_in_ready: got raised=%0d want 0", ir);
      end
      n_checks++;
      if (t_last - t_first != 3 * D - 1 + 3) begin
         n_fail++; $display("FAIL backpressure_duration: got %0d want %0d", t_last - t_first, 3 * D + 2);
      end
   endtask

   task automatic test_en_toggle();
      bit to_s, to, p1, p2, p3, h, ir;
      logic [D-1:0] bits, lasts;
      int lat;
      blk_vec[0] = 4'b0000; blk_vec[1] = 4'b0000; blk_vec[2] = 4'b0100; blk_vec[3] = 4'b0000;
      blk_best = 2'd3;
      model();
      send_block(2, 0, to_s, p1);
      pause_en(p2);
      recv_block(-1, 0, 0, 1, bits, lasts, lat, h, ir, p3, to);
      n_checks++;
      if (to_s || to || bits !== exp_bits || lasts !== exp_lasts) begin
         n_fail++; $display("FAIL en_toggle_data: got bits %b lasts %b want bits %b lasts %b", bits, lasts, exp_bits, exp_lasts);
      end
      n_checks++;
      if ({p1, p2, p3} !== 3'b000) begin
         n_fail++; $display("FAIL en_toggle_masking: got %b want 000", {p1, p2, p3});
      end
      n_checks++;
      if (t_last - t_first != 3 * D - 1 + 6) begin
         n_fail++; $display("FAIL en_toggle_duration: got %0d want %0d", t_last - t_first, 3 * D + 5);
      end
   endtask

   task automatic test_back_to_back();
      bit to_s, to, perr, h, ir, pe;
      logic [D-1:0] bits, lasts;
      int lat;
      rand_block();
      model();
      send_block(-1, 1, to_s, perr);
      recv_block(-1, 0, 0, -1, bits, lasts, lat, h, ir, pe, to);
      n_checks++;
      if (to_s || to || bits !== exp_bits || lasts !== exp_lasts) begin
         n_fail++; $display("FAIL b2b_block1: got bits %b lasts %b want bits %b lasts %b", bits, lasts, exp_bits, exp_lasts);
      end
      rand_block();
      model();
      dec_vec = blk_vec[0]; best_state = blk_best; in_valid = 1'b1;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready);
      end
      send_block(-1, 0, to_s, perr);
      recv_block(-1, 0, 0, -1, bits, lasts, lat, h, ir, pe, to);
      n_checks++;
      if (to_s || to || bits !== exp_bits || lasts !== exp_lasts) begin
         n_fail++; $display("FAIL b2b_block2: got bits %b lasts %b want bits %b lasts %b", bits, lasts, exp_bits, exp_lasts);
      end
      n_checks++;
      if (lat != D + 1) begin
         n_fail++; $display("FAIL b2b_latency: got %0d want %0d", lat, D + 1);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_en_toggle();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
